// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready load/store handshake. The response is valid LATENCY cycles after acceptance.
// While a response waits for rsp_ready, all outputs hold and no new request is accepted.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LIMIT    = 32'(4 * DEPTH);
    localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             addr_err;
    logic             access;
    logic             do_write;

    assign idx      = addr_q[IDX_W+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q >= LIMIT);
    assign access   = (state_q == WAIT) && (cnt_q == 3'd0);
    assign do_write = access && we_q && !addr_err;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    // Stores and faulting accesses return zero data.
                    err_d   = addr_err;
                    rdata_d = (we_q || addr_err) ? 32'h0 : mem_q[idx];
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately unreset; a reset mid-WAIT drops state_q to IDLE so the write never fires.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Two responders (LATENCY 1 and 4, DEPTH 32) driven with directed and random traffic.
// Expected data comes from a word-array model of the memory kept in the bench.
module tb_dmem_responder;
    logic        clk;
    logic        reset_n   [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          lat_of [2];
    logic [31:0] mdl [2][32];
    int          chk_cnt;
    int          pass_cnt;

    dmem_responder #(.DEPTH(32), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(32), .LATENCY(4)) u_lat4 (
        .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference memory: spec-level rules applied to a plain word array.
    function automatic void model(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [3:0] be, output logic [31:0] erd, output logic eer);
        int          w;
        logic [31:0] mask;
        eer  = ((a % 4) != 0) || (a >= 32'd128);
        erd  = 32'h0;
        w    = int'(a / 4);
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (!eer) begin
            if (we) mdl[d][w] = (mdl[d][w] & ~mask) | (wd & mask);
            else    erd = mdl[d][w];
        end
    endfunction

    task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd; req_be[d] = be;
        rsp_ready[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
        lat = 0;
        while (!rsp_valid[d] && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid[d]) lat = -1;
        rd = rsp_rdata[d]; er = rsp_err[d];
        @(negedge clk); rsp_ready[d] = 1'b1;
        @(posedge clk); #1; rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        for (int d = 0; d < 2; d++) begin
            reset_n[d] = 1'b0; req_valid[d] = 1'b1; req_we[d] = 1'b1;
            req_addr[d] = 32'h10; req_wdata[d] = 32'hCAFEF00D; req_be[d] = 4'hF; rsp_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk_cnt++; if (rsp_valid[d] !== 1'b0) $display("FAIL reset_rsp_valid[%0d] got %b want 0", d, rsp_valid[d]); else pass_cnt++;
            chk_cnt++; if (rsp_rdata[d] !== 32'h0) $display("FAIL reset_rsp_rdata[%0d] got %h want 0", d, rsp_rdata[d]); else pass_cnt++;
            chk_cnt++; if (rsp_err[d] !== 1'b0) $display("FAIL reset_rsp_err[%0d] got %b want 0", d, rsp_err[d]); else pass_cnt++;
            chk_cnt++; if (req_ready[d] !== 1'b1) $display("FAIL reset_req_ready[%0d] got %b want 1", d, req_ready[d]); else pass_cnt++;
        end
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; rsp_ready[d] = 1'b0; reset_n[d] = 1'b1;
        end
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL reset_release_idle got %0d busy samples want 0", bad); else pass_cnt++;
    endtask

    task automatic test_fill(input int d);
        logic [31:0] rd, erd, wd;
        logic        er, eer;
        int          lat;
        for (int i = 0; i < 32; i++) begin
            wd = $urandom;
            xact(d, 1'b1, 32'(4 * i), wd, 4'hF, rd, er, lat);
            model(d, 1'b1, 32'(4 * i), wd, 4'hF, erd, eer);
            chk_cnt++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL fill[%0d] word %0d got err=%b rdata=%h want err=0 rdata=0", d, i, er, rd); else pass_cnt++;
            chk_cnt++; if (lat != lat_of[d]) $display("FAIL fill_latency[%0d] got %0d want %0d", d, lat, lat_of[d]); else pass_cnt++;
        end
    endtask

    task automatic test_store_load(input int d);
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat;
        xact(d, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        model(d, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        chk_cnt++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL store_rsp[%0d] got err=%b rdata=%h want err=0 rdata=0", d, er, rd); else pass_cnt++;
        chk_cnt++; if (lat != lat_of[d]) $display("FAIL store_latency[%0d] got %0d want %0d", d, lat, lat_of[d]); else pass_cnt++;
        xact(d, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk_cnt++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) $display("FAIL load_rsp[%0d] got err=%b rdata=%h want err=0 rdata=deadbeef", d, er, rd); else pass_cnt++;
        chk_cnt++; if (lat != lat_of[d]) $display("FAIL load_latency[%0d] got %0d want %0d", d, lat, lat_of[d]); else pass_cnt++;
        xact(d, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er, lat);
        model(d, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, erd, eer);
        chk_cnt++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL partial_store_rsp[%0d] got err=%b rdata=%h want err=0 rdata=0", d, er, rd); else pass_cnt++;
        xact(d, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        chk_cnt++; if (rd !== 32'hDEADAAEF) $display("FAIL partial_load[%0d] got %h want deadaaef", d, rd); else pass_cnt++;
        xact(d, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        chk_cnt++; if (er !== 1'b0) $display("FAIL be0_store_err[%0d] got %b want 0", d, er); else pass_cnt++;
        xact(d, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk_cnt++; if (rd !== 32'hDEADAAEF) $display("FAIL be0_noop[%0d] got %h want deadaaef", d, rd); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp0, exp1;
        int          n, bad, lat;
        exp0 = mdl[0][4];
        exp1 = mdl[0][5];
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'h0; rsp_ready[0] = 1'b0;
        n = 0;
        while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_addr[0] = 32'h14;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
        bad = 0;
        repeat (5) begin
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== exp0 || req_ready[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk_cnt++; if (bad != 0) $display("FAIL bp_hold got %0d unstable samples want 0 (rdata %h want %h)", bad, rsp_rdata[0], exp0); else pass_cnt++;
        @(negedge clk); rsp_ready[0] = 1'b1;
        @(posedge clk); #1; rsp_ready[0] = 1'b0;
        chk_cnt++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", rsp_valid[0], req_ready[0]); else pass_cnt++;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk_cnt++; if (req_ready[0] !== 1'b0) $display("FAIL bp_reaccept got ready=%b want 0", req_ready[0]); else pass_cnt++;
        lat = 0;
        while (!rsp_valid[0] && lat < 20) begin @(posedge clk); #1; lat++; end
        chk_cnt++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== exp1 || lat != 1) $display("FAIL bp_second_load got valid=%b rdata=%h lat=%0d want valid=1 rdata=%h lat=1", rsp_valid[0], rsp_rdata[0], lat, exp1); else pass_cnt++;
        @(negedge clk); rsp_ready[0] = 1'b1;
        @(posedge clk); #1; rsp_ready[0] = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(0, 1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
        chk_cnt++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_misaligned_load got err=%b rdata=%h want err=1 rdata=0", er, rd); else pass_cnt++;
        xact(0, 1'b1, 32'h80, 32'h12345678, 4'hF, rd, er, lat);
        chk_cnt++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_range_store got err=%b rdata=%h want err=1 rdata=0", er, rd); else pass_cnt++;
        xact(0, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, lat);
        chk_cnt++; if (er !== 1'b0 || rd !== mdl[0][0]) $display("FAIL err_no_wrap got err=%b rdata=%h want err=0 rdata=%h", er, rd, mdl[0][0]); else pass_cnt++;
        xact(0, 1'b0, 32'h00010000, 32'h0, 4'h0, rd, er, lat);
        chk_cnt++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_high_addr got err=%b rdata=%h want err=1 rdata=0", er, rd); else pass_cnt++;
    endtask

    task automatic test_random(input int d);
        logic [31:0] a, wd, rd, erd;
        logic [3:0]  be;
        logic        we, er, eer;
        int          lat;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0, 1: a = 32'(4 * $urandom_range(0, 31));
                2:    a = 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
                default: a = 32'h80 + 32'($urandom_range(0, 1000));
            endcase
            we = 1'($urandom); wd = $urandom; be = 4'($urandom);
            xact(d, we, a, wd, be, rd, er, lat);
            model(d, we, a, wd, be, erd, eer);
            chk_cnt++; if (rd !== erd || er !== eer || lat != lat_of[d]) $display("FAIL random[%0d] we=%b addr=%h got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d", d, we, a, rd, er, lat, erd, eer, lat_of[d]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, n, seen;
        xact(1, 1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat);
        model(1, 1'b1, 32'h20, 32'h11111111, 4'hF, erd, eer);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'h55555555; req_be[1] = 4'hF;
        n = 0;
        while (!req_ready[1] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1; req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n[1] = 1'b1;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (rsp_valid[1] !== 1'b0) seen++; end
        chk_cnt++; if (seen != 0) $display("FAIL rst_wait_no_rsp got %0d valid samples want 0", seen); else pass_cnt++;
        xact(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk_cnt++; if (rd !== 32'h11111111 || er !== 1'b0) $display("FAIL rst_wait_no_commit got rdata=%h err=%b want rdata=11111111 err=0", rd, er); else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        lat_of[0] = 1; lat_of[1] = 4;
        for (int d = 0; d < 2; d++) begin
            reset_n[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
            req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = 1'b0;
        end
        #2;
        test_reset();
        test_fill(0);
        test_fill(1);
        test_store_load(0);
        test_store_load(1);
        test_backpressure();
        test_errors();
        test_random(0);
        test_random(1);
        test_reset_wait();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
